mod_lsu_ctrl: RTL and testbench

Load/store sequencing controller between the execute stage and the byte-enabled data memory port. It accepts one load or store request at a time and decodes funct3 and the unaligned address into a word-aligned address, a byteenable mask and shifted write data. It drives an Avalon-style read/write handshake with waitrequest, then returns sign- or zero-extended load data with a single-cycle response pulse. Misaligned and illegal accesses are trapped without touching memory.

---
 rtl/mod_lsu_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mod_lsu_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_lsu_ctrl.sv
// Load/store sequencer: decodes funct3/address into a byte-enabled Avalon-style access,
// waits out waitrequest, and returns extended load data with a one-cycle response pulse.
module mod_lsu_ctrl #(
    parameter int unsigned XLEN             = 32,
    parameter int unsigned BYTEENABLE_WIDTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic                        req_write_i,
    input  logic [2:0]                  funct3_i,
    input  logic [XLEN-1:0]             addr_i,
    input  logic [XLEN-1:0]             wdata_i,
    output logic                        resp_valid_o,
    output logic [XLEN-1:0]             rdata_o,
    output logic                        misaligned_o,
    output logic [XLEN-1:0]             mem_address_o,
    output logic [BYTEENABLE_WIDTH-1:0] mem_byteenable_o,
    output logic                        mem_read_o,
    output logic                        mem_write_o,
    output logic [XLEN-1:0]             mem_writedata_o,
    input  logic                        mem_waitrequest_i,
    input  logic [XLEN-1:0]             mem_readdata_i
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ACCESS = 3'd1;
    localparam logic [2:0] RDATA  = 3'd2;
    localparam logic [2:0] DONE   = 3'd3;
    localparam logic [2:0] ERR    = 3'd4;

    logic [2:0]                  state_q;
    logic                        write_q;
    logic [2:0]                  funct3_q;
    logic [1:0]                  off_q;
    logic                        resp_valid_q;
    logic                        misaligned_q;
    logic [XLEN-1:0]             rdata_q;
    logic [XLEN-1:0]             mem_address_q;
    logic [BYTEENABLE_WIDTH-1:0] mem_byteenable_q;
    logic                        mem_read_q;
    logic                        mem_write_q;
    logic [XLEN-1:0]             mem_writedata_q;

    logic [1:0]                  off;
    logic                        illegal;
    logic                        misaligned;
    logic [BYTEENABLE_WIDTH-1:0] be_dec;
    logic [XLEN-1:0]             wdata_dec;
    logic [XLEN-1:0]             shifted;
    logic [XLEN-1:0]             load_ext;

    assign off = addr_i[1:0];

    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        be_dec     = '0;
        wdata_dec  = '0;
        // Loads allow 0,1,2,4,5; stores allow only 0,1,2.
        if (req_write_i) begin
            illegal = funct3_i[2] | (funct3_i[1:0] == 2'b11);
        end else begin
            illegal = (funct3_i[1:0] == 2'b11) | (funct3_i == 3'b110);
        end
        case (funct3_i[1:0])
            2'b00: begin
                be_dec    = BYTEENABLE_WIDTH'(4'b0001) << off;
                wdata_dec = XLEN'(wdata_i[7:0]) << {off, 3'b000};
            end
            2'b01: begin
                be_dec     = BYTEENABLE_WIDTH'(4'b0011) << off;
                wdata_dec  = XLEN'(wdata_i[15:0]) << {off, 3'b000};
                misaligned = (off == 2'b11);
            end
            default: begin
                be_dec     = BYTEENABLE_WIDTH'(4'b1111);
                wdata_dec  = wdata_i;
                misaligned = (off != 2'b00);
            end
        endcase
    end

    always_comb begin
        shifted = mem_readdata_i >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= IDLE;
            write_q          <= 1'b0;
            funct3_q         <= 3'b000;
            off_q            <= 2'b00;
            resp_valid_q     <= 1'b0;
            misaligned_q     <= 1'b0;
            rdata_q          <= '0;
            mem_address_q    <= '0;
            mem_byteenable_q <= '0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_writedata_q  <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        write_q  <= req_write_i;
                        funct3_q <= funct3_i;
                        off_q    <= off;
                        rdata_q  <= '0;
                        if (illegal || misaligned) begin
                            state_q <= ERR;
                        end else begin
                            state_q          <= ACCESS;
                            mem_address_q    <= {addr_i[XLEN-1:2], 2'b00};
                            mem_byteenable_q <= be_dec;
                            mem_writedata_q  <= wdata_dec;
                            mem_read_q       <= ~req_write_i;
                            mem_write_q      <= req_write_i;
                        end
                    end
                end
                ACCESS: begin
                    if (!mem_waitrequest_i) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        state_q     <= write_q ? DONE : RDATA;
                    end
                end
                RDATA: begin
                    rdata_q <= load_ext;
                    state_q <= DONE;
                end
                DONE: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= IDLE;
                end
                ERR: begin
                    resp_valid_q <= 1'b1;
                    misaligned_q <= 1'b1;
                    rdata_q      <= '0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o      = (state_q == IDLE);
    assign resp_valid_o     = resp_valid_q;
    assign misaligned_o     = misaligned_q;
    assign rdata_o          = rdata_q;
    assign mem_address_o    = mem_address_q;
    assign mem_byteenable_o = mem_byteenable_q;
    assign mem_read_o       = mem_read_q;
    assign mem_write_o      = mem_write_q;
    assign mem_writedata_o  = mem_writedata_q;

endmodule

// File: tb/tb_mod_lsu_ctrl.sv
// Scoreboard bench for mod_lsu_ctrl: byte-level reference memory, randomized Avalon slave,
// expected responses and memory transactions queued at issue and checked by monitors.
module tb_mod_lsu_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_write_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        resp_valid_o;
    logic [31:0] rdata_o;
    logic        misaligned_o;
    logic [31:0] mem_address_o;
    logic [3:0]  mem_byteenable_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [31:0] mem_writedata_o;
    logic        mem_waitrequest_i = 1'b0;
    logic [31:0] mem_readdata_i = '0;

    mod_lsu_ctrl dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_write_i      (req_write_i),
        .funct3_i         (funct3_i),
        .addr_i           (addr_i),
        .wdata_i          (wdata_i),
        .resp_valid_o     (resp_valid_o),
        .rdata_o          (rdata_o),
        .misaligned_o     (misaligned_o),
        .mem_address_o    (mem_address_o),
        .mem_byteenable_o (mem_byteenable_o),
        .mem_read_o       (mem_read_o),
        .mem_write_o      (mem_write_o),
        .mem_writedata_o  (mem_writedata_o),
        .mem_waitrequest_i(mem_waitrequest_i),
        .mem_readdata_i   (mem_readdata_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int force_stalls = -1;

    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          acc_cyc;
        int          base_lat;
    } resp_t;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } memtxn_t;

    resp_t   exp_q[$];
    memtxn_t mem_q[$];
    int      stall_q[$];

    logic [7:0]  mbytes[logic [31:0]];
    logic [31:0] smem[logic [31:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] w);
        return (w * 32'h9E3779B9) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [7:0] mget(input logic [31:0] a);
        logic [31:0] w;
        if (mbytes.exists(a)) return mbytes[a];
        w = init_word(a >> 2);
        return w[8*a[1:0] +: 8];
    endfunction

    function automatic logic [31:0] sget(input logic [31:0] w);
        if (smem.exists(w)) return smem[w];
        return init_word(w);
    endfunction

    // Reference model: request semantics as byte-level memory operations.
    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        int          n;
        int          off;
        int          guard;
        bit          bad;
        resp_t       r;
        memtxn_t     t;
        logic [31:0] val;
        guard = 0;
        @(negedge clk_i);
        while (!req_ready_o && guard < 50) begin
            @(negedge clk_i);
            guard++;
        end
        if (!req_ready_o) check("ready_timeout", {31'b0, req_ready_o}, 32'd1);
        n   = 1 << f3[1:0];
        off = int'(addr[1:0]);
        bad = wr ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        if (!bad && (off + n > 4)) bad = 1'b1;
        r.acc_cyc = cyc + 1;
        val = '0;
        if (bad) begin
            r.rdata = '0; r.mis = 1'b1; r.base_lat = 1;
        end else begin
            t.write = wr;
            t.addr  = {addr[31:2], 2'b00};
            t.be    = 4'(((1 << n) - 1) << off);
            r.mis   = 1'b0;
            if (wr) begin
                for (int i = 0; i < n; i++) begin
                    val[8*(off+i) +: 8] = wd[8*i +: 8];
                    mbytes[addr + 32'(i)] = wd[8*i +: 8];
                end
                r.rdata = '0; r.base_lat = 2;
            end else begin
                for (int i = 0; i < n; i++) val[8*i +: 8] = mget(addr + 32'(i));
                if (!f3[2] && n < 4 && val[8*n-1]) val = val | ~((32'd1 << (8*n)) - 32'd1);
                r.rdata = val; r.base_lat = 3;
            end
            t.wdata = wr ? val : 32'h0;
            mem_q.push_back(t);
        end
        exp_q.push_back(r);
        req_valid_i = 1'b1;
        req_write_i = wr;
        funct3_i    = f3;
        addr_i      = addr;
        wdata_i     = wd;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        req_write_i = 1'($urandom);
        funct3_i    = 3'($urandom);
        addr_i      = $urandom;
        wdata_i     = $urandom;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(negedge clk_i);
            g++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        smem[a >> 2] = w;
        for (int i = 0; i < 4; i++) mbytes[{a[31:2], 2'b00} + 32'(i)] = w[8*i +: 8];
    endtask

    // Response monitor.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (mem_read_o && mem_write_o) check("strobe_overlap", 32'd1, 32'd0);
            if (resp_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    resp_t e;
                    int    lat;
                    e = exp_q.pop_front();
                    check("rdata", rdata_o, e.rdata);
                    check("misaligned", {31'b0, misaligned_o}, {31'b0, e.mis});
                    lat = e.base_lat;
                    if (!e.mis) begin
                        if (stall_q.size() == 0) check("stall_record", 32'd0, 32'd1);
                        else lat += stall_q.pop_front();
                    end
                    check("latency", 32'(cyc - e.acc_cyc), 32'(lat));
                end
            end
        end
    end

    // Avalon slave with random waitrequest; checks address phase and its stability.
    initial begin
        bit          in_txn = 1'b0;
        bit          rd_pending = 1'b0;
        int          stalls_left = 0;
        int          stall_cnt = 0;
        logic [31:0] rd_word = '0;
        logic [31:0] w;
        memtxn_t     cur;
        memtxn_t     e;
        forever begin
            @(posedge clk_i);
            #1;
            if (!rst_ni) begin
                in_txn = 1'b0;
                rd_pending = 1'b0;
                mem_waitrequest_i = 1'b0;
                continue;
            end
            if (rd_pending) begin
                mem_readdata_i = sget(rd_word);
                rd_pending = 1'b0;
            end else begin
                mem_readdata_i = $urandom;
            end
            if (mem_read_o || mem_write_o) begin
                if (!in_txn) begin
                    in_txn      = 1'b1;
                    stall_cnt   = 0;
                    stalls_left = (force_stalls >= 0) ? force_stalls : int'($urandom_range(0, 3));
                    cur.write = mem_write_o;
                    cur.addr  = mem_address_o;
                    cur.be    = mem_byteenable_o;
                    cur.wdata = mem_writedata_o;
                    if (mem_q.size() == 0) begin
                        check("unexpected_strobe", 32'd1, 32'd0);
                    end else begin
                        e = mem_q.pop_front();
                        check("mem_write", {31'b0, mem_write_o}, {31'b0, e.write});
                        check("mem_address", mem_address_o, e.addr);
                        check("mem_byteenable", {28'b0, mem_byteenable_o}, {28'b0, e.be});
                        if (e.write) check("mem_writedata", mem_writedata_o, e.wdata);
                    end
                end else begin
                    check("hold_write", {31'b0, mem_write_o}, {31'b0, cur.write});
                    check("hold_address", mem_address_o, cur.addr);
                    check("hold_byteenable", {28'b0, mem_byteenable_o}, {28'b0, cur.be});
                    check("hold_writedata", mem_writedata_o, cur.wdata);
                end
                if (stalls_left > 0) begin
                    mem_waitrequest_i = 1'b1;
                    stalls_left--;
                    stall_cnt++;
                end else begin
                    mem_waitrequest_i = 1'b0;
                    in_txn = 1'b0;
                    stall_q.push_back(stall_cnt);
                    if (cur.write) begin
                        w = sget(cur.addr >> 2);
                        for (int i = 0; i < 4; i++)
                            if (cur.be[i]) w[8*i +: 8] = cur.wdata[8*i +: 8];
                        smem[cur.addr >> 2] = w;
                    end else begin
                        rd_pending = 1'b1;
                        rd_word = cur.addr >> 2;
                    end
                end
            end else begin
                mem_waitrequest_i = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        wr;
        logic [2:0]  f3;
        int          k;
        repeat (3) @(negedge clk_i);
        check("rst_ready", {31'b0, req_ready_o}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid_o}, 32'd0);
        check("rst_misaligned", {31'b0, misaligned_o}, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_strobes", {30'b0, mem_read_o, mem_write_o}, 32'd0);
        check("rst_address", mem_address_o, 32'd0);
        check("rst_byteenable", {28'b0, mem_byteenable_o}, 32'd0);
        check("rst_writedata", mem_writedata_o, 32'd0);
        rst_ni = 1'b1;

        force_stalls = 0;
        issue(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB);
        wait_drain();
        preload(32'h2000, 32'h0000_F100);
        issue(1'b0, 3'b000, 32'h0000_2001, 32'h0);
        issue(1'b0, 3'b100, 32'h0000_2001, 32'h0);
        wait_drain();
        preload(32'h3000, 32'h8001_1234);
        force_stalls = 3;
        issue(1'b0, 3'b001, 32'h0000_3002, 32'h0);
        wait_drain();
        force_stalls = -1;
        issue(1'b0, 3'b010, 32'h0000_4002, 32'h0);
        issue(1'b0, 3'b011, 32'h0000_4000, 32'h0);
        issue(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF);
        issue(1'b0, 3'b010, 32'h0000_0010, 32'h0);
        wait_drain();

        for (int i = 0; i < 300; i++) begin
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                f3 = 3'($urandom);
            end else if (wr) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                k = int'($urandom_range(0, 4));
                f3 = 3'(k > 2 ? k + 1 : k);
            end
            issue(wr, f3, 32'h100 + 32'($urandom_range(0, 63)), $urandom);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk_i);
        end
        wait_drain();

        // Reset in the middle of a stalled load.
        force_stalls = 100;
        issue(1'b0, 3'b010, 32'h0000_0020, 32'h0);
        repeat (3) @(negedge clk_i);
        check("stall_read_high", {31'b0, mem_read_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        check("rst_read_drop", {31'b0, mem_read_o}, 32'd0);
        check("rst_no_resp", {31'b0, resp_valid_o}, 32'd0);
        exp_q.delete();
        force_stalls = -1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("post_rst_ready", {31'b0, req_ready_o}, 32'd1);
        repeat (4) @(negedge clk_i);
        issue(1'b1, 3'b001, 32'h0000_0121, 32'h0000_BEEF);
        issue(1'b0, 3'b101, 32'h0000_0121, 32'h0);
        wait_drain();
        repeat (5) @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
